// File: rtl/map_bank_irq_pkg.sv
// Shared definitions for the bank-switching core: save-state byte indexes,
// timer control bit positions and CPU write-region decode types.
package map_bank_irq_pkg;

  localparam logic [7:0] SS_CHR0   = 8'd0;
  localparam logic [7:0] SS_PRG    = 8'd16;
  localparam logic [7:0] SS_RLD    = 8'd17;
  localparam logic [7:0] SS_RLD_HI = 8'd18;
  localparam logic [7:0] SS_CNT    = 8'd19;
  localparam logic [7:0] SS_CNT_HI = 8'd20;
  localparam logic [7:0] SS_CTL    = 8'd21;
  localparam logic [7:0] SS_IDX    = 8'd127;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_REP = 1;

  // CPU $8000-$FFFF split by cpu_addr[14:13]
  typedef enum logic [1:0] {
    RgnPrgLo = 2'b00,
    RgnChr   = 2'b01,
    RgnPrgHi = 2'b10,
    RgnIrq   = 2'b11
  } cpu_rgn_e;

  // $E000-$FFFF register select by cpu_addr[1:0]
  typedef enum logic [1:0] {
    IrqRldLo = 2'b00,
    IrqRldHi = 2'b01,
    IrqCtrl  = 2'b10,
    IrqAck   = 2'b11
  } irq_reg_e;

endpackage

// File: rtl/map_irq_timer.sv
// Reloadable CPU-cycle down-counter IRQ with save-state access to reload,
// counter and {pending, ctrl}. All state updates on the falling edge of m2.
module map_irq_timer
  import map_bank_irq_pkg::*;
#(
  parameter int unsigned IRQ_BITS = 16
) (
  input  logic       m2,
  input  logic       map_rst,
  input  logic       ss_act,
  input  logic       ss_we,
  input  logic [7:0] ss_addr,
  input  logic [7:0] wr_dat,
  input  logic       wr_en,
  input  logic [1:0] wr_sel,
  output logic       irq,
  output logic       ss_hit,
  output logic [7:0] ss_rdat
);

  localparam int unsigned HI_BITS = IRQ_BITS - 8;

  logic [IRQ_BITS-1:0] rld_q, rld_d;
  logic [IRQ_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]          ctl_q, ctl_d;
  logic                pend_q, pend_d;

  always_comb begin
    rld_d  = rld_q;
    cnt_d  = cnt_q;
    ctl_d  = ctl_q;
    pend_d = pend_q;
    if (ss_act) begin
      if (ss_we) begin
        case (ss_addr)
          SS_RLD:    rld_d[7:0]          = wr_dat;
          SS_RLD_HI: rld_d[IRQ_BITS-1:8] = wr_dat[HI_BITS-1:0];
          SS_CNT:    cnt_d[7:0]          = wr_dat;
          SS_CNT_HI: cnt_d[IRQ_BITS-1:8] = wr_dat[HI_BITS-1:0];
          SS_CTL:    {pend_d, ctl_d}     = wr_dat[2:0];
          default:   ;
        endcase
      end
    end else begin
      if (ctl_q[CTRL_EN]) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - IRQ_BITS'(1);
        end else begin
          pend_d = 1'b1;
          if (ctl_q[CTRL_REP]) begin
            cnt_d = rld_q;
          end else begin
            ctl_d[CTRL_EN] = 1'b0;
          end
        end
      end
      // CPU writes are applied last so a same-cycle ctrl/ack write beats expiry
      if (wr_en) begin
        unique case (irq_reg_e'(wr_sel))
          IrqRldLo: rld_d[7:0]          = wr_dat;
          IrqRldHi: rld_d[IRQ_BITS-1:8] = wr_dat[HI_BITS-1:0];
          IrqCtrl: begin
            ctl_d  = wr_dat[1:0];
            cnt_d  = rld_q;
            pend_d = 1'b0;
          end
          IrqAck:   pend_d = 1'b0;
        endcase
      end
    end
  end

  always_ff @(negedge m2) begin
    if (map_rst) begin
      rld_q  <= '0;
      cnt_q  <= '0;
      ctl_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      rld_q  <= rld_d;
      cnt_q  <= cnt_d;
      ctl_q  <= ctl_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    ss_hit = (ss_addr >= SS_RLD) && (ss_addr <= SS_CTL);
    case (ss_addr)
      SS_RLD:    ss_rdat = rld_q[7:0];
      SS_RLD_HI: ss_rdat = 8'(rld_q[IRQ_BITS-1:8]);
      SS_CNT:    ss_rdat = cnt_q[7:0];
      SS_CNT_HI: ss_rdat = 8'(cnt_q[IRQ_BITS-1:8]);
      SS_CTL:    ss_rdat = {5'b0, pend_q, ctl_q};
      default:   ss_rdat = 8'hFF;
    endcase
  end

  assign irq = pend_q;

endmodule

// File: rtl/map_bank_irq.sv
// Parametrised CHR/PRG bank switching for NES mappers with an attached IRQ
// timer. Address outputs are combinational from the bank registers.
module map_bank_irq
  import map_bank_irq_pkg::*;
#(
  parameter int unsigned CHR_SLOTS     = 4,
  parameter int unsigned CHR_BANK_BITS = 8,
  parameter int unsigned PRG_BANK_BITS = 4,
  parameter int unsigned IRQ_BITS      = 16
) (
  input  logic                      m2,
  input  logic                      map_rst,
  input  logic [15:0]               cpu_addr,
  input  logic [7:0]                cpu_dat,
  input  logic                      cpu_rw,
  input  logic [13:0]               ppu_addr,
  input  logic                      ss_act,
  input  logic                      ss_we,
  input  logic [7:0]                ss_addr,
  input  logic [7:0]                map_idx,
  output logic [17:0]               prg_addr,
  output logic [11+CHR_BANK_BITS-1:0] chr_addr,
  output logic                      irq,
  output logic [7:0]                ss_rdat
);

  localparam int unsigned SLOT_BITS = $clog2(CHR_SLOTS);
  localparam int unsigned SLOT_W    = (SLOT_BITS > 0) ? SLOT_BITS : 1;
  localparam int unsigned OFS_BITS  = 13 - SLOT_BITS;
  localparam int unsigned CHR_W     = 11 + CHR_BANK_BITS;
  localparam logic [7:0]  CHR_SLOTS_B = 8'(CHR_SLOTS);
  localparam logic [SLOT_W-1:0] SLOT_MASK = SLOT_W'(CHR_SLOTS - 1);

  logic [CHR_SLOTS-1:0][CHR_BANK_BITS-1:0] chr_q, chr_d;
  logic [PRG_BANK_BITS-1:0]                prg_q, prg_d;

  logic              cpu_wr;
  cpu_rgn_e          rgn;
  logic [SLOT_W-1:0] cpu_slot, ppu_slot, ss_slot;
  logic [7:0]        ss_chr_idx;
  logic [3:0]        prg_bank;
  logic              tmr_hit;
  logic [7:0]        tmr_rdat;
  logic              unused_ppu;

  assign unused_ppu = ppu_addr[13];

  always_comb begin
    cpu_wr     = !cpu_rw && !ss_act && cpu_addr[15];
    rgn        = cpu_rgn_e'(cpu_addr[14:13]);
    cpu_slot   = SLOT_W'(cpu_addr[2:0]) & SLOT_MASK;
    ss_slot    = SLOT_W'(ss_addr[2:0]) & SLOT_MASK;
    ss_chr_idx = ss_addr - SS_CHR0;
    ppu_slot   = SLOT_W'(ppu_addr[12:0] >> OFS_BITS);
  end

  always_comb begin
    chr_d = chr_q;
    prg_d = prg_q;
    if (ss_act) begin
      if (ss_we && (ss_chr_idx < CHR_SLOTS_B)) begin
        chr_d[ss_slot] = CHR_BANK_BITS'(cpu_dat);
      end
      if (ss_we && (ss_addr == SS_PRG)) begin
        prg_d = cpu_dat[PRG_BANK_BITS-1:0];
      end
    end else if (cpu_wr) begin
      unique case (rgn)
        RgnChr:           chr_d[cpu_slot] = CHR_BANK_BITS'(cpu_dat);
        // Top bit records which of the two PRG windows was written
        RgnPrgLo, RgnPrgHi: prg_d = {cpu_addr[14], cpu_dat[PRG_BANK_BITS-2:0]};
        default:          ;
      endcase
    end
  end

  always_ff @(negedge m2) begin
    if (map_rst) begin
      chr_q <= '0;
      prg_q <= '0;
    end else begin
      chr_q <= chr_d;
      prg_q <= prg_d;
    end
  end

  map_irq_timer #(
    .IRQ_BITS(IRQ_BITS)
  ) u_timer (
    .m2      (m2),
    .map_rst (map_rst),
    .ss_act  (ss_act),
    .ss_we   (ss_we),
    .ss_addr (ss_addr),
    .wr_dat  (cpu_dat),
    .wr_en   (cpu_wr && (rgn == RgnIrq)),
    .wr_sel  (cpu_addr[1:0]),
    .irq     (irq),
    .ss_hit  (tmr_hit),
    .ss_rdat (tmr_rdat)
  );

  always_comb begin
    prg_bank = 4'(prg_q);
    prg_addr = {(cpu_addr[14] ? 4'h0 : prg_bank), cpu_addr[13:0]};
    chr_addr = CHR_W'({chr_q[ppu_slot], ppu_addr[OFS_BITS-1:0]});
  end

  always_comb begin
    if (ss_chr_idx < CHR_SLOTS_B) begin
      ss_rdat = 8'(chr_q[ss_slot]);
    end else if (ss_addr == SS_PRG) begin
      ss_rdat = 8'(prg_q);
    end else if (tmr_hit) begin
      ss_rdat = tmr_rdat;
    end else if (ss_addr == SS_IDX) begin
      ss_rdat = map_idx;
    end else begin
      ss_rdat = 8'hFF;
    end
  end

endmodule

// File: tb/tb_map_bank_irq.sv
// Directed bench for map_bank_irq: table-driven bank mapping vectors plus
// hand-written IRQ timer, reset and save-state sequences.
module tb_map_bank_irq;

  logic        m2 = 1'b0;
  logic        map_rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dat;
  logic        cpu_rw;
  logic [13:0] ppu_addr;
  logic        ss_act;
  logic        ss_we;
  logic [7:0]  ss_addr;
  logic [7:0]  map_idx;
  logic [17:0] prg_addr;
  logic [18:0] chr_addr;
  logic        irq;
  logic [7:0]  ss_rdat;

  int n_pass  = 0;
  int n_total = 0;

  map_bank_irq #(
    .CHR_SLOTS     (4),
    .CHR_BANK_BITS (8),
    .PRG_BANK_BITS (4),
    .IRQ_BITS      (16)
  ) dut (
    .m2       (m2),
    .map_rst  (map_rst),
    .cpu_addr (cpu_addr),
    .cpu_dat  (cpu_dat),
    .cpu_rw   (cpu_rw),
    .ppu_addr (ppu_addr),
    .ss_act   (ss_act),
    .ss_we    (ss_we),
    .ss_addr  (ss_addr),
    .map_idx  (map_idx),
    .prg_addr (prg_addr),
    .chr_addr (chr_addr),
    .irq      (irq),
    .ss_rdat  (ss_rdat)
  );

  initial forever #5 m2 = ~m2;

  typedef struct {
    logic [15:0] waddr;
    logic [7:0]  wdat;
    logic [15:0] caddr;
    logic [13:0] paddr;
    logic [17:0] prg;
    logic [18:0] chr;
  } map_vec_t;

  typedef struct {
    logic [7:0] idx;
    logic [7:0] dat;
    logic [7:0] exp;
  } ss_vec_t;

  map_vec_t vecs [8];
  ss_vec_t  ssv  [10];

  task automatic tick();
    @(negedge m2);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_dat  = d;
    cpu_rw   = 1'b0;
    tick();
    cpu_rw   = 1'b1;
  endtask

  task automatic ss_write(input logic [7:0] a, input logic [7:0] d);
    ss_addr = a;
    cpu_dat = d;
    ss_we   = 1'b1;
    tick();
    ss_we   = 1'b0;
  endtask

  task automatic ss_read(input string name, input logic [7:0] a, input logic [7:0] exp);
    ss_addr = a;
    #1;
    check(name, 32'(ss_rdat), 32'(exp));
  endtask

  task automatic chk_irq(input string name, input logic exp);
    check(name, 32'(irq), 32'(exp));
  endtask

  initial begin
    vecs[0] = '{16'h0000, 8'h00, 16'h8123, 14'h0A34, 18'h00123, 19'h00234};
    vecs[1] = '{16'hA001, 8'h2A, 16'h8123, 14'h0A34, 18'h00123, 19'h15234};
    vecs[2] = '{16'h8000, 8'h05, 16'h8123, 14'h0234, 18'h14123, 19'h00234};
    vecs[3] = '{16'h0000, 8'h00, 16'hC123, 14'h1FFF, 18'h00123, 19'h007FF};
    vecs[4] = '{16'hC000, 8'h02, 16'hBFFF, 14'h1800, 18'h2BFFF, 19'h00000};
    vecs[5] = '{16'hA003, 8'hFF, 16'hFFFF, 14'h1FFF, 18'h03FFF, 19'h7FFFF};
    vecs[6] = '{16'hBFFE, 8'h81, 16'h4000, 14'h1001, 18'h00000, 19'h40801};
    vecs[7] = '{16'hDFFF, 8'h07, 16'h0ABC, 14'h0A34, 18'h3CABC, 19'h15234};

    ssv[0] = '{8'd0,  8'h11, 8'h11};
    ssv[1] = '{8'd1,  8'h22, 8'h22};
    ssv[2] = '{8'd2,  8'h33, 8'h33};
    ssv[3] = '{8'd3,  8'h44, 8'h44};
    ssv[4] = '{8'd16, 8'hF9, 8'h09};
    ssv[5] = '{8'd17, 8'h05, 8'h05};
    ssv[6] = '{8'd18, 8'h00, 8'h00};
    ssv[7] = '{8'd19, 8'h02, 8'h02};
    ssv[8] = '{8'd20, 8'h00, 8'h00};
    ssv[9] = '{8'd21, 8'hF9, 8'h01};

    map_rst  = 1'b1;
    cpu_addr = 16'h0000;
    cpu_dat  = 8'h00;
    cpu_rw   = 1'b1;
    ppu_addr = 14'h0000;
    ss_act   = 1'b0;
    ss_we    = 1'b0;
    ss_addr  = 8'h00;
    map_idx  = 8'hA5;
    idle(2);
    map_rst  = 1'b0;

    chk_irq("reset_irq", 1'b0);
    ss_act = 1'b1;
    ss_read("reset_ctl", 8'd21, 8'h00);
    ss_read("reset_cnt", 8'd19, 8'h00);
    ss_read("reset_rld", 8'd17, 8'h00);
    ss_act = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cpu_write(vecs[i].waddr, vecs[i].wdat);
      cpu_addr = vecs[i].caddr;
      ppu_addr = vecs[i].paddr;
      #1;
      check($sformatf("vec%0d_prg", i), 32'(prg_addr), 32'(vecs[i].prg));
      check($sformatf("vec%0d_chr", i), 32'(chr_addr), 32'(vecs[i].chr));
    end

    // One-shot, reload 3: irq four cycles after $E002
    cpu_write(16'hE000, 8'h03);
    cpu_write(16'hE001, 8'h00);
    cpu_write(16'hE002, 8'h01);
    idle(3);
    chk_irq("oneshot_early", 1'b0);
    idle(1);
    chk_irq("oneshot_fire", 1'b1);
    cpu_write(16'hE003, 8'h00);
    chk_irq("oneshot_ack", 1'b0);
    idle(10);
    chk_irq("oneshot_no_second", 1'b0);
    ss_act = 1'b1;
    ss_read("oneshot_en_clear", 8'd21, 8'h00);
    ss_act = 1'b0;

    // Repeat, reload 2: every three cycles with acks, then held without ack
    cpu_write(16'hE000, 8'h02);
    cpu_write(16'hE002, 8'h03);
    idle(2);
    chk_irq("rep_early", 1'b0);
    idle(1);
    chk_irq("rep_fire0", 1'b1);
    for (int i = 0; i < 2; i++) begin
      cpu_write(16'hE003, 8'h00);
      chk_irq($sformatf("rep_ack%0d", i), 1'b0);
      idle(1);
      chk_irq($sformatf("rep_gap%0d", i), 1'b0);
      idle(1);
      chk_irq($sformatf("rep_fire%0d", i + 1), 1'b1);
    end
    idle(5);
    chk_irq("rep_held", 1'b1);
    cpu_write(16'hE002, 8'h00);
    chk_irq("rep_stop", 1'b0);

    // Reload write at expiry under repeat: counter takes the old reload (2)
    cpu_write(16'hE002, 8'h03);
    idle(2);
    cpu_write(16'hE000, 8'h05);
    chk_irq("rldwr_fire", 1'b1);
    cpu_write(16'hE003, 8'h00);
    chk_irq("rldwr_ack", 1'b0);
    idle(1);
    chk_irq("rldwr_gap", 1'b0);
    idle(1);
    chk_irq("rldwr_old_period", 1'b1);
    cpu_write(16'hE002, 8'h00);

    // Ack in the expiry cycle wins (reload 5, expiry 6 cycles after $E002)
    cpu_write(16'hE002, 8'h01);
    idle(5);
    cpu_write(16'hE003, 8'h00);
    chk_irq("ack_at_expiry", 1'b0);
    idle(5);
    chk_irq("ack_at_expiry_after", 1'b0);

    // Reload 0 expires on the first enabled cycle
    cpu_write(16'hE000, 8'h00);
    cpu_write(16'hE002, 8'h01);
    chk_irq("r0_write", 1'b0);
    idle(1);
    chk_irq("r0_fire", 1'b1);
    cpu_write(16'hE003, 8'h00);
    idle(3);
    chk_irq("r0_quiet", 1'b0);

    // Reset mid-count
    cpu_write(16'hE000, 8'h10);
    cpu_write(16'hE002, 8'h01);
    idle(3);
    map_rst = 1'b1;
    tick();
    map_rst = 1'b0;
    chk_irq("rst_mid_irq", 1'b0);
    ss_act = 1'b1;
    ss_read("rst_mid_cnt", 8'd19, 8'h00);
    ss_read("rst_mid_ctl", 8'd21, 8'h00);
    ss_read("rst_mid_rld", 8'd17, 8'h00);
    ss_read("rst_mid_chr1", 8'd1, 8'h00);
    ss_act = 1'b0;
    idle(20);
    chk_irq("rst_mid_no_irq", 1'b0);

    // Save state: freeze, read, restore
    cpu_write(16'hE000, 8'h34);
    cpu_write(16'hE001, 8'h12);
    cpu_write(16'hE002, 8'h01);
    ss_act = 1'b1;
    ss_read("ss_cnt_lo", 8'd19, 8'h34);
    ss_read("ss_cnt_hi", 8'd20, 8'h12);
    idle(3);
    ss_read("ss_cnt_frozen", 8'd19, 8'h34);
    ss_read("ss_ctl_live", 8'd21, 8'h01);
    cpu_write(16'hA000, 8'h77);
    for (int i = 0; i < 10; i++) ss_write(ssv[i].idx, ssv[i].dat);
    for (int i = 0; i < 10; i++) ss_read($sformatf("ss_rb%0d", ssv[i].idx), ssv[i].idx, ssv[i].exp);
    ss_read("ss_map_idx", 8'd127, 8'hA5);
    ss_read("ss_idx30", 8'd30, 8'hFF);
    ss_read("ss_idx5", 8'd5, 8'hFF);
    ss_act   = 1'b0;
    ppu_addr = 14'h0A34;
    cpu_addr = 16'h8000;
    #1;
    check("ss_restored_chr", 32'(chr_addr), 32'h11234);
    check("ss_restored_prg", 32'(prg_addr), 32'h24000);
    idle(2);
    chk_irq("ss_resume_early", 1'b0);
    idle(1);
    chk_irq("ss_resume_fire", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
